// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int unsigned WDefault = 3;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and seq_divider (slave).
interface seq_divider_if #(
  parameter int unsigned W = div_pkg::WDefault
) ();

  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// Trial subtract r - divisor for one restoring step: ripple of full adders on ~divisor, cin = 1.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = WDefault
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a    (r[i]),
      .b    (~divisor[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // Top stage subtracts a zero divisor bit; only its carry matters since a kept
  // difference is always below the divisor and fits in W bits.
  assign borrow = ~(r[W] | carry[W]);

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned W = WDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned    CntW     = $clog2(2 * W + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(2 * W - 1);

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [2*W-1:0] dvd_q, dvd_d;
  logic [W-1:0]   dsr_q, dsr_d;
  logic [W-1:0]   r_q, r_d;
  logic [2*W-1:0] quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  logic [W:0]     r_shift;
  logic [W-1:0]   diff;
  logic           borrow;

  assign r_shift = {r_q, dvd_q[2*W-1]};

  div_step #(.W(W)) u_step (
    .r       (r_shift),
    .divisor (dsr_q),
    .diff    (diff),
    .borrow  (borrow)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            state_d = StCalc;
            dvd_d   = bus.dividend;
            dsr_d   = bus.divisor;
            r_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      StCalc: begin
        r_d   = borrow ? r_shift[W-1:0] : diff;
        dvd_d = {dvd_q[2*W-2:0], ~borrow};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          state_d     = StDone;
          quotient_d  = dvd_d;
          remainder_d = r_d;
          dbz_d       = 1'b0;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == StCalc);
  assign bus.done        = (state_q == StDone);
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (W=3): latency, handshake, div-by-zero, reset, sweep.
module tb_seq_divider;
  import div_pkg::*;

  localparam int unsigned W = WDefault;

  typedef struct packed {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one request and let the accepting edge pass; expected result goes to the scoreboard.
  task automatic drive_op(input logic [2*W-1:0] dd, input logic [W-1:0] ds);
    exp_t e;
    if (ds == '0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1;
    end else begin
      e.q = (2*W)'(dd / ds); e.r = W'(dd % ds); e.dbz = 1'b0;
    end
    sb.push_back(e);
    bus.dividend = dd;
    bus.divisor  = ds;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // lat = cycle number (1 = first cycle after the accept) in which done is seen.
  task automatic wait_done(output int lat, output int busy_cnt, output bit ok, output bit ovl);
    lat = 0; busy_cnt = 0; ok = 1'b0; ovl = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.busy && bus.done) ovl = 1'b1;
      if (bus.done) begin
        lat = n; ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: busy/done/dbz=%b want 000",
                         {bus.busy, bus.done, bus.div_by_zero});
    end
    n_tests++;
    if ({bus.quotient, bus.remainder} !== '0) begin
      n_fail++; $display("FAIL reset_results: q=%0d r=%0d want 0 0", bus.quotient, bus.remainder);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int lat, bc; bit ok, ovl; exp_t e;
    drive_op(6'd42, 3'd6);
    wait_done(lat, bc, ok, ovl);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 7) begin
      n_fail++; $display("FAIL basic_latency: done in cycle %0d want 7", lat);
    end
    n_tests++;
    if (bc != 6) begin
      n_fail++; $display("FAIL basic_busy: busy cycles %0d want 6", bc);
    end
    n_tests++;
    if (ovl) begin
      n_fail++; $display("FAIL basic_overlap: busy and done high together, want never");
    end
    n_tests++;
    if (bus.quotient !== 6'd7 || bus.quotient !== e.q || bus.remainder !== e.r
        || bus.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: q=%0d r=%0d dbz=%b want 7 0 0",
                         bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.done !== 1'b0 || bus.quotient !== e.q) begin
      n_fail++; $display("FAIL basic_pulse: done=%b q=%0d want 0 %0d", bus.done, bus.quotient, e.q);
    end
  endtask

  task automatic test_values();
    logic [2*W-1:0] dds [3] = '{6'd63, 6'd5, 6'd0};
    logic [W-1:0]   dss [3] = '{3'd5, 3'd7, 3'd3};
    logic [2*W-1:0] qs  [3] = '{6'd12, 6'd0, 6'd0};
    logic [W-1:0]   rs  [3] = '{3'd3, 3'd5, 3'd0};
    int lat, bc; bit ok, ovl; exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_op(dds[i], dss[i]);
      wait_done(lat, bc, ok, ovl);
      e = sb.pop_front();
      n_tests++;
      if (!ok || bus.quotient !== qs[i] || bus.remainder !== rs[i] || bus.quotient !== e.q) begin
        n_fail++; $display("FAIL value_%0d: %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", i,
                           dds[i], dss[i], bus.quotient, bus.remainder, qs[i], rs[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; bit ok, ovl; exp_t e;
    drive_op(6'd17, 3'd0);
    wait_done(lat, bc, ok, ovl);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 1 || bc != 0) begin
      n_fail++; $display("FAIL dbz_timing: done cycle %0d busy cycles %0d want 1 0", lat, bc);
    end
    n_tests++;
    if (bus.quotient !== 6'd63 || bus.remainder !== 3'd0 || bus.div_by_zero !== 1'b1
        || bus.quotient !== e.q) begin
      n_fail++; $display("FAIL dbz_result: q=%0d r=%0d dbz=%b want 63 0 1",
                         bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_after: done=%b busy=%b dbz=%b want 0 0 1",
                         bus.done, bus.busy, bus.div_by_zero);
    end
  endtask

  task automatic test_ignored_start();
    int lat, bc; bit ok, ovl; exp_t e;
    drive_op(6'd63, 3'd5);
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 6'd10; bus.divisor = 3'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bc, ok, ovl);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 4) begin
      n_fail++; $display("FAIL ignore_latency: done after %0d more cycles want 4", lat);
    end
    n_tests++;
    if (bus.quotient !== 6'd12 || bus.remainder !== 3'd3 || bus.quotient !== e.q) begin
      n_fail++; $display("FAIL ignore_result: q=%0d r=%0d want 12 3", bus.quotient, bus.remainder);
    end
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if (bus.quotient !== 6'd12 || bus.remainder !== 3'd3 || bus.done !== 1'b0
        || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_hold: q=%0d r=%0d done=%b busy=%b want 12 3 0 0",
                         bus.quotient, bus.remainder, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit ok, ovl; exp_t e;
    drive_op(6'd63, 3'd5);
    void'(sb.pop_back());
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0
        || bus.remainder !== '0) begin
      n_fail++; $display("FAIL rst_mid: busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                         bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    drive_op(6'd49, 3'd7);
    wait_done(lat, bc, ok, ovl);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 7 || bus.quotient !== 6'd7 || bus.remainder !== 3'd0
        || bus.quotient !== e.q) begin
      n_fail++; $display("FAIL rst_recover: cycle %0d q=%0d r=%0d want 7 7 0",
                         lat, bus.quotient, bus.remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap; bit ok, ovl, seen; exp_t e;
    sb.push_back('{q: 6'd7, r: 3'd0, dbz: 1'b0});
    bus.dividend = 6'd42; bus.divisor = 3'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    // Operands change after the accept: only the second request may see them.
    bus.dividend = 6'd63; bus.divisor = 3'd5;
    sb.push_back('{q: 6'd12, r: 3'd3, dbz: 1'b0});
    wait_done(lat, bc, ok, ovl);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 7 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      n_fail++; $display("FAIL b2b_first: cycle %0d q=%0d r=%0d want 7 %0d %0d",
                         lat, bus.quotient, bus.remainder, e.q, e.r);
    end
    gap = 0; seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      gap++;
      if (bus.done) begin seen = 1'b1; break; end
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!seen || gap != 8) begin
      n_fail++; $display("FAIL b2b_period: done-to-done %0d cycles want 8", gap);
    end
    n_tests++;
    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
      n_fail++; $display("FAIL b2b_second: q=%0d r=%0d want %0d %0d",
                         bus.quotient, bus.remainder, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat, bc; bit ok, ovl; exp_t e;
    for (int dd = 0; dd < 64; dd++) begin
      for (int ds = 1; ds < 8; ds++) begin
        drive_op((2*W)'(dd), W'(ds));
        wait_done(lat, bc, ok, ovl);
        e = sb.pop_front();
        n_tests++;
        if (!ok || ovl || lat != 7 || bus.quotient !== e.q || bus.remainder !== e.r
            || bus.div_by_zero !== e.dbz) begin
          n_fail++; $display("FAIL sweep %0d/%0d: q=%0d r=%0d dbz=%b lat=%0d want %0d %0d 0 7",
                             dd, ds, bus.quotient, bus.remainder, bus.div_by_zero, lat,
                             e.q, e.r);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
